// File: rtl/mmss_display_scan_pkg.sv
// Shared constants for the MM.SS display scanner: segment codes, digit slots,
// capture FSM states and the double-dabble iteration count.
package mmss_disp_pkg;

  localparam int unsigned CONV_ITERS = 6;

  // Segment codes are {g,f,e,d,c,b,a}, active-low (common anode)
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF  = 7'b1111111;

  localparam logic [1:0] DIG_SEC_ONES = 2'd0;
  localparam logic [1:0] DIG_SEC_TENS = 2'd1;
  localparam logic [1:0] DIG_MIN_ONES = 2'd2;
  localparam logic [1:0] DIG_MIN_TENS = 2'd3;

  // Out-of-range fields are stored as this pseudo-digit
  localparam logic [3:0] DIGIT_DASH = 4'hA;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:       return SEG_0;
      4'd1:       return SEG_1;
      4'd2:       return SEG_2;
      4'd3:       return SEG_3;
      4'd4:       return SEG_4;
      4'd5:       return SEG_5;
      4'd6:       return SEG_6;
      4'd7:       return SEG_7;
      4'd8:       return SEG_8;
      4'd9:       return SEG_9;
      DIGIT_DASH: return SEG_DASH;
      default:    return SEG_OFF;
    endcase
  endfunction

endpackage

// File: rtl/mmss_display_scan_if.sv
// Capture bus and display pins of the MM.SS scanner; the counter chain / board
// side is the master, the scanner is the slave.
interface mmss_display_scan_if;
  logic [5:0] min_in;
  logic [5:0] sec_in;
  logic       load;
  logic       blank;
  logic       busy;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (output min_in, sec_in, load, blank, input busy, an, seg, dp);
  modport slave  (input min_in, sec_in, load, blank, output busy, an, seg, dp);
endinterface

// File: rtl/bin6_to_bcd_seq.sv
// Sequential 6-bit binary to two-digit BCD converter (shift-add-3), one bit
// per clock; ovf flags inputs above 59 at start.
module bin6_to_bcd_seq
  import mmss_disp_pkg::*;
(
  input  logic       clk,
  input  logic       clr,
  input  logic       start,
  input  logic [5:0] bin,
  output logic       done,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       ovf
);

  logic [13:0] sr;
  logic [13:0] sr_adj;
  logic [2:0]  cnt;
  logic        active;

  function automatic logic [3:0] adj(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_comb begin
    sr_adj = {adj(sr[13:10]), adj(sr[9:6]), sr[5:0]};
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      sr     <= '0;
      cnt    <= '0;
      active <= 1'b0;
      ovf    <= 1'b0;
    end else if (start) begin
      sr     <= {8'd0, bin};
      cnt    <= '0;
      active <= 1'b1;
      ovf    <= (bin > 6'd59);
    end else if (active) begin
      sr  <= {sr_adj[12:0], 1'b0};
      cnt <= cnt + 3'd1;
      if (cnt == 3'(CONV_ITERS - 1)) active <= 1'b0;
    end
  end

  // High during the cycle whose closing edge performs the final shift
  assign done = active && (cnt == 3'(CONV_ITERS - 1));
  assign tens = sr[13:10];
  assign ones = sr[9:6];

endmodule

// File: rtl/mmss_display_scan.sv
// Captures minutes/seconds, converts to BCD and scans a 4-digit common-anode
// 7-segment display as MM.SS with registered outputs.
module mmss_display_scan
  import mmss_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DP_DIGIT = 2
) (
  input logic              clk,
  input logic              clr,
  mmss_display_scan_if.slave bus
);

  state_t state, state_nxt;
  logic start;
  logic min_done, sec_done, min_ovf, sec_ovf;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic [3:0][3:0] dig;
  logic [15:0] pre;
  logic [1:0]  idx;

  bin6_to_bcd_seq u_min (
    .clk(clk), .clr(clr), .start(start), .bin(bus.min_in),
    .done(min_done), .tens(min_tens), .ones(min_ones), .ovf(min_ovf)
  );

  bin6_to_bcd_seq u_sec (
    .clk(clk), .clr(clr), .start(start), .bin(bus.sec_in),
    .done(sec_done), .tens(sec_tens), .ones(sec_ones), .ovf(sec_ovf)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.load) state_nxt = CONV;
      CONV:    if (min_done && sec_done) state_nxt = COMMIT;
      COMMIT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    start    = (state == IDLE) && bus.load;
    bus.busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      dig <= '0;
    end else if (state == COMMIT) begin
      dig[DIG_SEC_ONES] <= sec_ovf ? DIGIT_DASH : sec_ones;
      dig[DIG_SEC_TENS] <= sec_ovf ? DIGIT_DASH : sec_tens;
      dig[DIG_MIN_ONES] <= min_ovf ? DIGIT_DASH : min_ones;
      dig[DIG_MIN_TENS] <= min_ovf ? DIGIT_DASH : min_tens;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      pre <= '0;
      idx <= '0;
    end else if (pre == 16'(SCAN_DIV - 1)) begin
      pre <= '0;
      idx <= idx + 2'd1;
    end else begin
      pre <= pre + 16'd1;
    end
  end

  // Driven from the pre-edge index, so pins trail idx by one clock
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      bus.an  <= '1;
      bus.seg <= SEG_OFF;
      bus.dp  <= 1'b1;
    end else if (bus.blank) begin
      bus.an  <= '1;
      bus.seg <= SEG_OFF;
      bus.dp  <= 1'b1;
    end else begin
      bus.an  <= ~(4'b0001 << idx);
      bus.seg <= seg_of(dig[idx]);
      bus.dp  <= ~(idx == 2'(DP_DIGIT));
    end
  end

endmodule

// File: tb/tb_mmss_display_scan.sv
// Self-checking bench for mmss_display_scan: constant digit tables, hand
// sequences for busy/reset corners, and random traffic against an edge-count model.
module tb_mmss_display_scan;

  localparam int unsigned SD = 4;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  mmss_display_scan_if bus ();

  mmss_display_scan #(.SCAN_DIV(SD), .DP_DIGIT(2)) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  // Model: edges since reset release, capture phase, pending fields, shown digits (10 = dash)
  int cyc;
  int phase;
  int pmin, psec;
  int mdisp [4];
  int last_idx;

  typedef struct {
    logic [5:0]      mn;
    logic [5:0]      sc;
    logic [3:0][6:0] exp;   // exp[k] = seg code for digit k (0 = sec ones)
  } vec_t;

  vec_t tbl [5];

  function automatic logic [6:0] seg_code(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      10: return 7'b0111111;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    cyc   = 0;
    phase = 0;
    for (int i = 0; i < 4; i++) mdisp[i] = 0;
  endtask

  task automatic model_commit();
    mdisp[0] = (psec > 59) ? 10 : psec % 10;
    mdisp[1] = (psec > 59) ? 10 : psec / 10;
    mdisp[2] = (pmin > 59) ? 10 : pmin % 10;
    mdisp[3] = (pmin > 59) ? 10 : pmin / 10;
  endtask

  task automatic step(input logic blk, input logic ld, input logic [5:0] mn, input logic [5:0] sc);
    int idx;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp, e_busy;
    bus.blank  = blk;
    bus.load   = ld;
    bus.min_in = mn;
    bus.sec_in = sc;
    idx      = (cyc / SD) % 4;
    last_idx = idx;
    e_an  = blk ? 4'hF : ~(4'b0001 << idx);
    e_seg = blk ? 7'h7F : seg_code(mdisp[idx]);
    e_dp  = !(idx == 2 && !blk);
    if (phase == 0) begin
      if (ld) begin
        pmin  = mn;
        psec  = sc;
        phase = 1;
      end
    end else if (phase == 7) begin
      model_commit();
      phase = 0;
    end else begin
      phase++;
    end
    e_busy = (phase != 0);
    cyc++;
    @(posedge clk);
    #1;
    check("busy", 32'(bus.busy), 32'(e_busy));
    check("an",   32'(bus.an),   32'(e_an));
    check("seg",  32'(bus.seg),  32'(e_seg));
    check("dp",   32'(bus.dp),   32'(e_dp));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 6'd0, 6'd0);
  endtask

  task automatic scan_check(input string tag, input logic [3:0][6:0] exp);
    for (int i = 0; i < int'(4 * SD); i++) begin
      step(1'b0, 1'b0, 6'd0, 6'd0);
      if ((cyc - 1) % SD == 0) check(tag, 32'(bus.seg), 32'(exp[last_idx]));
    end
  endtask

  task automatic check_reset_pins(input string tag);
    check({tag, "_an"},   32'(bus.an),   32'hF);
    check({tag, "_seg"},  32'(bus.seg),  32'h7F);
    check({tag, "_dp"},   32'(bus.dp),   32'h1);
    check({tag, "_busy"}, 32'(bus.busy), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tbl[0] = '{6'd12, 6'd34, {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001}};
    tbl[1] = '{6'd59, 6'd0,  {7'b0010010, 7'b0010000, 7'b1000000, 7'b1000000}};
    tbl[2] = '{6'd61, 6'd59, {7'b0111111, 7'b0111111, 7'b0010010, 7'b0010000}};
    tbl[3] = '{6'd5,  6'd7,  {7'b1000000, 7'b0010010, 7'b1000000, 7'b1111000}};
    tbl[4] = '{6'd63, 6'd60, {7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111}};

    bus.load = 1'b0; bus.blank = 1'b0; bus.min_in = '0; bus.sec_in = '0;
    clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_pins("rst");
    clr = 1'b1;
    model_reset();
    scan_check("rst_zero", {4{7'b1000000}});

    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, tbl[i].mn, tbl[i].sc);
      idle(8);
      scan_check($sformatf("tbl%0d", i), tbl[i].exp);
    end

    // Loads during conversion and on the edge busy falls must both be dropped
    step(1'b0, 1'b1, 6'd59, 6'd0);
    idle(2);
    step(1'b0, 1'b1, 6'd1, 6'd1);
    idle(3);
    step(1'b0, 1'b1, 6'd1, 6'd1);
    check("busy_fall", 32'(bus.busy), 32'h0);
    idle(2);
    scan_check("ignored", {7'b0010010, 7'b0010000, 7'b1000000, 7'b1000000});

    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 6'd0, 6'd0);
    idle(2 * SD);

    // Reset in the middle of a conversion
    step(1'b0, 1'b1, 6'd45, 6'd45);
    idle(3);
    clr = 1'b0;
    #1;
    check_reset_pins("midconv");
    repeat (2) @(posedge clk);
    #1;
    clr = 1'b1;
    model_reset();
    scan_check("after_clr", {4{7'b1000000}});
    step(1'b0, 1'b1, 6'd12, 6'd34);
    idle(7);
    check("latency_idle", 32'(bus.busy), 32'h0);
    scan_check("reload", tbl[0].exp);

    for (int i = 0; i < 400; i++)
      step(($urandom % 8) == 0, ($urandom % 6) == 0, 6'($urandom % 64), 6'($urandom % 64));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
